// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// The scoreboard entry layout and FSM encoding are used by the top and the per-source matcher.
package hazard_fwd_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLuStall  = 2'd1,
        StMemHold  = 2'd2,
        StRedirect = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 wben;
        logic                 is_load;
    } sb_entry_t;

    // Width of a forwarding select: 0 = regfile, 1..depth = stage.
    function automatic int unsigned hz_selw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// One EX source operand: priority match over the post-EX scoreboard stages and the data mux.
// The youngest (lowest stage index) eligible writer wins; otherwise the regfile value passes.
module hazard_fwd_ctrl_fwd_match
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned FWD_DEPTH      = 3,
    parameter int unsigned LOAD_READY_STG = 2,
    parameter int unsigned SELW           = hz_selw(FWD_DEPTH)
) (
    input  logic [REG_IDX_W-1:0]      rs_idx_i,
    input  logic                      rs_used_i,
    input  sb_entry_t [FWD_DEPTH-1:0] sb_i,
    input  logic [FWD_DEPTH*XLEN-1:0] fwd_data_i,
    input  logic [XLEN-1:0]           rf_data_i,
    output logic [SELW-1:0]           sel_o,
    output logic [XLEN-1:0]           data_o
);

    logic found;

    // sb_i[k-1] holds stage k; a load is only usable once it reaches LOAD_READY_STG.
    always_comb begin
        sel_o  = '0;
        data_o = rf_data_i;
        found  = 1'b0;
        for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
            if (!found && rs_used_i && sb_i[k-1].valid && sb_i[k-1].wben &&
                (sb_i[k-1].rd != '0) && (sb_i[k-1].rd == rs_idx_i) &&
                !(sb_i[k-1].is_load && (k < LOAD_READY_STG))) begin
                found  = 1'b1;
                sel_o  = SELW'(k);
                data_o = fwd_data_i[(k-1)*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the in-order IF/ID/EX/LS/WB pipeline: tracks in-flight
// writers, forwards EX operands, interlocks load-use, flushes on redirect, freezes on mem busy.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned FWD_DEPTH      = 3,
    parameter int unsigned LOAD_READY_STG = 2,
    parameter int unsigned CNT_W          = 32,
    localparam int unsigned SELW          = hz_selw(FWD_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [NUM_SRC*REG_IDX_W-1:0]   id_rs_idx,
    input  logic [NUM_SRC-1:0]             id_rs_used,
    input  logic [REG_IDX_W-1:0]           id_rd_idx,
    input  logic                           id_wben,
    input  logic                           id_is_load,
    input  logic                           ex_jump,
    input  logic                           mem_busy,
    input  logic [FWD_DEPTH*XLEN-1:0]      fwd_data_i,
    input  logic [NUM_SRC*XLEN-1:0]        ex_rs_rf_i,
    output logic [NUM_SRC*XLEN-1:0]        ex_src_o,
    output logic [NUM_SRC*SELW-1:0]        fwd_sel_o,
    output logic                           stall_pc_o,
    output logic                           stall_id_o,
    output logic                           bubble_ex_o,
    output logic                           flush_id_o,
    output logic                           freeze_o,
    output logic [CNT_W-1:0]               stall_cnt_o,
    output logic [CNT_W-1:0]               flush_cnt_o,
    output logic [1:0]                     state_o
);

    // sb_q[0] is the instruction in EX, sb_q[k] the one k stages past EX.
    sb_entry_t [FWD_DEPTH:0]        sb_q, sb_d;
    logic [NUM_SRC*REG_IDX_W-1:0]   ex_rs_idx_q, ex_rs_idx_d;
    logic [NUM_SRC-1:0]             ex_rs_used_q, ex_rs_used_d;
    logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]               flush_cnt_q, flush_cnt_d;
    hz_state_e                      state_q, state_d;
    logic                           load_use;

    // A load at stage j reaches j+1 next cycle; it must be at LOAD_READY_STG to forward.
    always_comb begin
        load_use = 1'b0;
        for (int unsigned j = 0; (j + 2 <= LOAD_READY_STG) && (j <= FWD_DEPTH); j++) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                if (id_valid && id_rs_used[s] && sb_q[j].valid && sb_q[j].wben &&
                    sb_q[j].is_load && (sb_q[j].rd != '0) &&
                    (sb_q[j].rd == id_rs_idx[s*REG_IDX_W +: REG_IDX_W])) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sb_d         = sb_q;
        ex_rs_idx_d  = ex_rs_idx_q;
        ex_rs_used_d = ex_rs_used_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        state_d      = StRun;
        stall_pc_o   = 1'b0;
        stall_id_o   = 1'b0;
        bubble_ex_o  = 1'b0;
        flush_id_o   = 1'b0;
        freeze_o     = 1'b0;
        if (mem_busy) begin
            freeze_o = 1'b1;
            state_d  = StMemHold;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0]      = '0;
            ex_rs_idx_d  = '0;
            ex_rs_used_d = '0;
            if (ex_jump) begin
                flush_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
                state_d     = StRedirect;
                if (flush_cnt_q != '1) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end else if (load_use) begin
                stall_pc_o  = 1'b1;
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
                state_d     = StLuStall;
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end else begin
                sb_d[0]      = '{valid: id_valid, rd: id_rd_idx, wben: id_wben,
                                 is_load: id_is_load};
                ex_rs_idx_d  = id_rs_idx;
                ex_rs_used_d = id_rs_used;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q         <= '0;
            ex_rs_idx_q  <= '0;
            ex_rs_used_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            state_q      <= StRun;
        end else begin
            sb_q         <= sb_d;
            ex_rs_idx_q  <= ex_rs_idx_d;
            ex_rs_used_q <= ex_rs_used_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            state_q      <= state_d;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_fwd_ctrl_fwd_match #(
            .XLEN           (XLEN),
            .FWD_DEPTH      (FWD_DEPTH),
            .LOAD_READY_STG (LOAD_READY_STG),
            .SELW           (SELW)
        ) u_match (
            .rs_idx_i   (ex_rs_idx_q[s*REG_IDX_W +: REG_IDX_W]),
            .rs_used_i  (ex_rs_used_q[s]),
            .sb_i       (sb_q[FWD_DEPTH:1]),
            .fwd_data_i (fwd_data_i),
            .rf_data_i  (ex_rs_rf_i[s*XLEN +: XLEN]),
            .sel_o      (fwd_sel_o[s*SELW +: SELW]),
            .data_o     (ex_src_o[s*XLEN +: XLEN])
        );
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign state_o     = state_q;

endmodule
